// File: rtl/csr_spi_bridge.sv
// SPI-slave command decoder for the mixer: host bytes become CSR reads/writes,
// PROM word writes and DRAM word bursts; read data returns MSB first on miso.
module csr_spi_bridge #(
  parameter int NUM_CH       = 8,
  parameter int NUM_SPDIF_IN = 3,
  parameter int NUM_RATE     = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sck,
  input  logic                             mosi,
  input  logic                             ss,
  output logic                             miso,
  input  logic [NUM_RATE*NUM_SPDIF_IN-1:0] rate_i,
  input  logic [192*NUM_SPDIF_IN-1:0]      udata_i,
  input  logic [192*NUM_SPDIF_IN-1:0]      cdata_i,
  output logic [8*NUM_CH-1:0]              vol_o,
  output logic                             nkmd_rst_o,
  output logic [31:0]                      nkmd_dbgin_o,
  output logic [19:0]                      prom_addr_o,
  output logic [31:0]                      prom_data_o,
  output logic                             prom_we_o,
  output logic [27:0]                      dram0_addr_o,
  output logic [31:0]                      dram0_data_o,
  output logic                             dram0_we_o,
  output logic                             dram0_pop_o,
  input  logic [31:0]                      dram0_data_i,
  input  logic                             dram0_ack_i,
  input  logic                             dram0_busy_i
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, SPECIAL, DRAM_ADDR, DRAM_DATA} state_t;
  state_t state, state_nx;

  logic [2:0]  sck_p;
  logic [1:0]  mosi_p, ss_p;
  logic        sck_rise, sck_fall, ss_hi, mosi_s;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sh;
  logic [7:0]  rx_byte, tx_sh;
  logic        rx_vld, rd_load, rd_dummy;
  logic        we_r, sel_r, dev0;
  logic [4:0]  units, pops_left;
  logic [1:0]  acnt, bidx;
  logic [19:0] addr;
  logic [27:0] daddr;
  logic [31:0] word, cur_word, nxt_word;
  logic        nxt_vld, wr_pend, pop_pend;
  logic        last_unit, word_end, csr_wr;

  function automatic logic [4:0] len_units(input logic [1:0] len);
    case (len)
      2'b01:   return 5'd1;
      2'b10:   return 5'd4;
      2'b11:   return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] csr_rd(input logic [11:0] a);
    logic [7:0] d;
    d = 8'h00;
    for (int k = 0; k < NUM_CH; k++)
      if (a == 12'(k)) d = vol_o[8*k +: 8];
    if (a == 12'h400) d = {7'b0, nkmd_rst_o};
    for (int k = 0; k < 4; k++)
      if (a == 12'h600 + 12'(k)) d = nkmd_dbgin_o[8*k +: 8];
    for (int i = 0; i < NUM_SPDIF_IN; i++)
      if (a == 12'h800 + 12'(i)) d = 8'(rate_i[NUM_RATE*i +: NUM_RATE]);
    for (int b = 0; b < 24*NUM_SPDIF_IN; b++) begin
      if (a == 12'h900 + 12'(b)) d = udata_i[8*b +: 8];
      if (a == 12'hA00 + 12'(b)) d = cdata_i[8*b +: 8];
    end
    return d;
  endfunction

  assign sck_rise    = sck_p[1] & ~sck_p[2];
  assign sck_fall    = ~sck_p[1] & sck_p[2];
  assign ss_hi       = ss_p[1];
  assign mosi_s      = mosi_p[1];
  assign miso        = tx_sh[7];
  assign last_unit   = (units == 5'd1);
  assign word_end    = (bidx == 2'd3);
  assign dram0_we_o  = wr_pend & ~dram0_busy_i;
  assign dram0_pop_o = pop_pend & ~nxt_vld & ~dram0_busy_i;

  // Stage 0: synchronize SPI pins and assemble bytes
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_p   <= '0;
      mosi_p  <= '0;
      ss_p    <= 2'b11;
      bit_cnt <= '0;
      rx_vld  <= 1'b0;
    end else begin
      sck_p  <= {sck_p[1:0], sck};
      mosi_p <= {mosi_p[0], mosi};
      ss_p   <= {ss_p[0], ss};
      rx_vld <= 1'b0;
      if (ss_hi) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx_sh   <= {rx_sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= {rx_sh, mosi_s};
          rx_vld  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    csr_wr   = 1'b0;
    if (rx_vld) begin
      case (state)
        IDLE:      if (rx_byte == 8'h0F) state_nx = SPECIAL;
                   else if (rx_byte[6:5] != 2'b00) state_nx = ADDR;
        ADDR:      if (acnt == 2'd0) state_nx = DATA;
        DATA: begin
          if (!sel_r) begin
            csr_wr = we_r;
            if (last_unit) state_nx = IDLE;
          end else if (word_end && last_unit) begin
            state_nx = IDLE;
          end
        end
        SPECIAL:   state_nx = (rx_byte[6:5] == 2'b00) ? IDLE : DRAM_ADDR;
        DRAM_ADDR: if (acnt == 2'd0) state_nx = DRAM_DATA;
        DRAM_DATA: if (!rd_dummy && word_end && last_unit) state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // Stage 1: per-byte datapath, miso shifter and PROM/DRAM handshakes
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_r <= 1'b0; sel_r <= 1'b0; dev0 <= 1'b0;
      units <= '0; pops_left <= '0; acnt <= '0; bidx <= '0;
      rd_load <= 1'b0; rd_dummy <= 1'b0; tx_sh <= '0;
      nxt_vld <= 1'b0; wr_pend <= 1'b0; pop_pend <= 1'b0;
      prom_we_o <= 1'b0; prom_addr_o <= '0; prom_data_o <= '0;
      dram0_addr_o <= '0; dram0_data_o <= '0;
    end else begin
      prom_we_o <= 1'b0;
      rd_load   <= 1'b0;
      if (dram0_we_o) wr_pend <= 1'b0;
      if (dram0_pop_o) begin
        pop_pend  <= 1'b0;
        pops_left <= pops_left - 5'd1;
      end
      // The follow-up request waits until this word leaves the prefetch slot.
      if (dram0_ack_i) begin
        nxt_word <= dram0_data_i;
        nxt_vld  <= 1'b1;
        if (pops_left != 5'd0) pop_pend <= 1'b1;
      end
      if (!ss_hi && sck_fall && bit_cnt != 3'd0) tx_sh <= {tx_sh[6:0], 1'b0};
      if (rd_load) tx_sh <= csr_rd(addr[11:0]);
      if (rx_vld) begin
        tx_sh <= 8'h00;
        case (state)
          IDLE: if (rx_byte != 8'h0F) begin
            we_r  <= rx_byte[7];
            sel_r <= rx_byte[4];
            units <= len_units(rx_byte[6:5]);
            addr  <= {16'h0, rx_byte[3:0]};
            acnt  <= rx_byte[4] ? 2'd1 : 2'd0;
          end
          ADDR: begin
            addr <= {addr[11:0], rx_byte};
            bidx <= '0;
            if (acnt == 2'd0) rd_load <= ~we_r & ~sel_r;
            else              acnt <= acnt - 2'd1;
          end
          DATA: begin
            if (!sel_r) begin
              addr[11:0] <= addr[11:0] + 12'd1;
              units      <= units - 5'd1;
              rd_load    <= ~we_r & ~last_unit;
            end else begin
              word <= {rx_byte, word[31:8]};
              bidx <= bidx + 2'd1;
              if (word_end) begin
                prom_we_o <= we_r;
                if (we_r) begin
                  prom_addr_o <= addr;
                  prom_data_o <= {rx_byte, word[31:8]};
                end
                addr  <= addr + 20'd1;
                units <= units - 5'd1;
              end
            end
          end
          SPECIAL: begin
            we_r  <= rx_byte[7];
            dev0  <= (rx_byte[3:0] == 4'h0);
            units <= len_units(rx_byte[6:5]);
            acnt  <= 2'd3;
          end
          DRAM_ADDR: begin
            daddr <= {daddr[19:0], rx_byte};
            bidx  <= '0;
            if (acnt != 2'd0) begin
              acnt <= acnt - 2'd1;
            end else if (!we_r) begin
              rd_dummy <= 1'b1;
              if (dev0) begin
                pop_pend  <= 1'b1;
                pops_left <= units;
              end
            end
          end
          DRAM_DATA: begin
            if (we_r) begin
              word <= {word[23:0], rx_byte};
              bidx <= bidx + 2'd1;
              if (word_end) begin
                if (dev0) begin
                  wr_pend      <= 1'b1;
                  dram0_addr_o <= daddr;
                  dram0_data_o <= {word[23:0], rx_byte};
                end
                daddr <= daddr + 28'd1;
                units <= units - 5'd1;
              end
            end else begin
              if (rd_dummy) begin
                rd_dummy <= 1'b0;
              end else begin
                bidx <= bidx + 2'd1;
                if (word_end) units <= units - 5'd1;
              end
              if (rd_dummy || (word_end && !last_unit)) begin
                if (nxt_vld && dev0) begin
                  tx_sh    <= nxt_word[31:24];
                  cur_word <= {nxt_word[23:0], 8'h00};
                  nxt_vld  <= 1'b0;
                end else begin
                  cur_word <= '0;
                end
              end else begin
                tx_sh    <= cur_word[31:24];
                cur_word <= {cur_word[23:0], 8'h00};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage 2: CSR register file
  always_ff @(posedge clk) begin
    if (!rst) begin
      vol_o        <= '0;
      nkmd_rst_o   <= 1'b0;
      nkmd_dbgin_o <= '0;
    end else if (csr_wr) begin
      for (int k = 0; k < NUM_CH; k++)
        if (addr[11:0] == 12'(k)) vol_o[8*k +: 8] <= rx_byte;
      if (addr[11:0] == 12'h400) nkmd_rst_o <= rx_byte[0];
      for (int k = 0; k < 4; k++)
        if (addr[11:0] == 12'h600 + 12'(k)) nkmd_dbgin_o[8*k +: 8] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_csr_spi_bridge.sv
// Directed bench for csr_spi_bridge: drives SPI mode-0 byte streams and checks
// CSR state, miso read data, PROM strobes and DRAM write/read handshakes.
module tb_csr_spi_bridge;

  logic         clk = 1'b0, rst = 1'b0;
  logic         sck = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic         miso;
  logic [14:0]  rate_i;
  logic [575:0] udata_i, cdata_i;
  logic [63:0]  vol_o;
  logic         nkmd_rst_o;
  logic [31:0]  nkmd_dbgin_o;
  logic [19:0]  prom_addr_o;
  logic [31:0]  prom_data_o;
  logic         prom_we_o;
  logic [27:0]  dram0_addr_o;
  logic [31:0]  dram0_data_o;
  logic         dram0_we_o, dram0_pop_o;
  logic [31:0]  dram0_data_i = '0;
  logic         dram0_ack_i = 1'b0, dram0_busy_i = 1'b0;

  int checks = 0, errors = 0;
  int prom_cnt = 0, dwr_cnt = 0, pop_cnt = 0;
  logic [19:0] exp_prom_addr;
  logic [31:0] exp_prom_data;
  logic        busy_run = 1'b0;
  logic [7:0]  txb[$], rxb[$];

  csr_spi_bridge dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss), .miso(miso),
    .rate_i(rate_i), .udata_i(udata_i), .cdata_i(cdata_i), .vol_o(vol_o),
    .nkmd_rst_o(nkmd_rst_o), .nkmd_dbgin_o(nkmd_dbgin_o),
    .prom_addr_o(prom_addr_o), .prom_data_o(prom_data_o), .prom_we_o(prom_we_o),
    .dram0_addr_o(dram0_addr_o), .dram0_data_o(dram0_data_o),
    .dram0_we_o(dram0_we_o), .dram0_pop_o(dram0_pop_o),
    .dram0_data_i(dram0_data_i), .dram0_ack_i(dram0_ack_i), .dram0_busy_i(dram0_busy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #80;
      r[i] = miso;
      sck = 1'b1;
      #80;
      sck = 1'b0;
    end
    #80;
  endtask

  task automatic xfer();
    logic [7:0] r;
    rxb.delete();
    ss = 1'b0;
    #80;
    foreach (txb[i]) begin
      spi_byte(txb[i], r);
      rxb.push_back(r);
    end
    ss = 1'b1;
    #200;
  endtask

  task automatic partial_bits(input int n);
    ss = 1'b0;
    #80;
    for (int i = 0; i < n; i++) begin
      mosi = 1'b1; #80; sck = 1'b1; #80; sck = 1'b0;
    end
    #80;
    ss = 1'b1;
    #200;
  endtask

  task automatic dram_responder();
    forever begin
      @(negedge clk);
      if (dram0_pop_o) begin
        repeat (5) @(negedge clk);
        dram0_data_i = {8'h10 + 8'(pop_cnt), 8'h20 + 8'(pop_cnt),
                        8'h30 + 8'(pop_cnt), 8'h40 + 8'(pop_cnt)};
        dram0_ack_i  = 1'b1;
        pop_cnt++;
        @(negedge clk);
        dram0_ack_i  = 1'b0;
      end
    end
  endtask

  task automatic busy_toggler();
    while (busy_run) begin
      @(posedge clk); #2 dram0_busy_i = 1'b1;
      repeat (40) @(posedge clk);
      #2 dram0_busy_i = 1'b0;
      repeat (25) @(posedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (prom_we_o) begin
      chk("prom_addr", 64'(prom_addr_o), 64'(exp_prom_addr));
      chk("prom_data", 64'(prom_data_o), 64'(exp_prom_data));
      prom_cnt++;
    end
    if (dram0_we_o) begin
      chk("dram_we_busy", 64'(dram0_busy_i), 64'd0);
      chk("dram_addr", 64'(dram0_addr_o), 64'(28'h2345678 + 28'(dwr_cnt)));
      chk("dram_data", 64'(dram0_data_o), 64'h0000_0000_EFBE_ADDE);
      dwr_cnt++;
    end
  end

  initial begin
    rate_i = {5'b00001, 5'b00100, 5'b10000};
    for (int b = 0; b < 72; b++) begin
      udata_i[8*b +: 8] = 8'h17 - 8'(b);
      cdata_i[8*b +: 8] = 8'hC0 + 8'(b);
    end
    fork dram_responder(); join_none
    repeat (4) @(negedge clk);
    chk("rst_vol", vol_o, 64'd0);
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_nkmd", 64'(nkmd_rst_o), 64'd0);
    chk("rst_dbgin", 64'(nkmd_dbgin_o), 64'd0);
    chk("rst_strobes", {61'd0, prom_we_o, dram0_we_o, dram0_pop_o}, 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    txb = '{8'hA0, 8'h03, 8'h99, 8'h00}; xfer();
    chk("vol_wr_byte3", vol_o, 64'h0000_0000_9900_0000);

    txb = '{8'h28, 8'h01, 8'h00, 8'h00}; xfer();
    chk("rate_rd", 64'(rxb[2]), 64'h04);
    chk("rate_rd_after", 64'(rxb[3]), 64'h00);

    txb = '{8'h49, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; xfer();
    for (int i = 0; i < 4; i++) chk("udata_burst", 64'(rxb[2+i]), 64'(8'h17 - 8'(i)));

    txb = '{8'h2A, 8'h05, 8'h00}; xfer();
    chk("cdata_rd", 64'(rxb[2]), 64'hC5);

    txb = '{8'hC0, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; xfer();
    chk("vol_burst", vol_o, 64'hDEAD_BEEF_9900_0000);
    txb = '{8'h20, 8'h07, 8'h00}; xfer();
    chk("vol7_rd", 64'(rxb[2]), 64'hDE);

    exp_prom_addr = 20'h00000; exp_prom_data = 32'hDEAD_BEEF;
    txb = '{8'hB0, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; xfer();
    chk("prom_cnt1", 64'(prom_cnt), 64'd1);
    exp_prom_addr = 20'h51234; exp_prom_data = 32'h4433_2211;
    txb = '{8'hB5, 8'h12, 8'h34, 8'h11, 8'h22, 8'h33, 8'h44}; xfer();
    chk("prom_cnt2", 64'(prom_cnt), 64'd2);

    txb = '{8'hA4, 8'h00, 8'h01}; xfer();
    chk("nkmd_set", 64'(nkmd_rst_o), 64'd1);
    txb = '{8'h24, 8'h00, 8'h00}; xfer();
    chk("nkmd_rd", 64'(rxb[2]), 64'h01);
    txb = '{8'hA4, 8'h00, 8'h00}; xfer();
    chk("nkmd_clr", 64'(nkmd_rst_o), 64'd0);
    txb = '{8'hA6, 8'h03, 8'hAC}; xfer();
    chk("dbgin_b3", 64'(nkmd_dbgin_o), 64'hAC00_0000);

    txb = '{8'hA1, 8'h23, 8'h55}; xfer();
    chk("unmapped_wr", vol_o, 64'hDEAD_BEEF_9900_0000);
    txb = '{8'h21, 8'h23, 8'h00}; xfer();
    chk("unmapped_rd", 64'(rxb[2]), 64'h00);

    txb = '{8'hCF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44}; xfer();
    chk("addr_wrap", vol_o, 64'hDEAD_BEEF_9944_3322);

    partial_bits(3);
    txb = '{8'hA0, 8'h01, 8'h5A}; xfer();
    chk("partial_discard", vol_o, 64'hDEAD_BEEF_9944_5A22);

    busy_run = 1'b1;
    fork busy_toggler(); join_none
    txb = '{8'h0F, 8'hC0, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int w = 0; w < 4; w++) begin
      txb.push_back(8'hEF); txb.push_back(8'hBE); txb.push_back(8'hAD); txb.push_back(8'hDE);
    end
    xfer();
    busy_run = 1'b0;
    #1500;
    chk("dram_wr_cnt", 64'(dwr_cnt), 64'd4);
    chk("dram_busy_idle", 64'(dram0_busy_i), 64'd0);

    txb = '{8'h0F, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 17; i++) txb.push_back(8'h00);
    xfer();
    chk("dram_dummy", 64'(rxb[6]), 64'h00);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        chk("dram_rd", 64'(rxb[7 + 4*k + j]), 64'(8'h10 * 8'(j + 1) + 8'(k)));
    chk("dram_pop_cnt", 64'(pop_cnt), 64'd4);

    txb = '{8'hA0, 8'h00, 8'h77}; xfer();
    chk("idle_after_dram", vol_o, 64'hDEAD_BEEF_9944_5A77);

    txb = '{8'hA0, 8'h02}; xfer();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_vol", vol_o, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    txb = '{8'hA0, 8'h05, 8'h66}; xfer();
    chk("rst_abort", vol_o, 64'h0000_6600_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
